kontroler_przerwan: RTL
=======================

# kontroler_przerwan

Vectored interrupt controller for the 8-bit core. It latches rising edges from `N_SRC` interrupt sources into a pending register and applies a per-source enable mask and a global enable. It picks the highest-priority source, lowest index first, and presents a vector to the ID stage over a req/ack handshake. It tracks the single in-service source until RETI, with no nesting.

## Interface
- `N_SRC`, 4: number of interrupt sources, 1..8; index 0 has highest priority.
- `VEC_BASE`, 8'h02: vector of source 0.
- `VEC_STEP`, 8'h02: vector spacing between consecutive sources.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset is synchronous and active-low (0 = reset).
- `int_src` in `N_SRC`: raw source levels (button, timer, ...); rising edge = event.
- `gie_set` in 1: SEI, sets global enable.
- `gie_clr` in 1: CLI, clears global enable.
- `mask_we` in 1: write strobe for mask register.
- `mask_wdata` in `N_SRC`: new mask value; 1 = source enabled.
- `irq_ack` in 1: ID stage has accepted the vector and is loading PC.
- `reti` in 1: RETI executed.
- `irq_req` out 1: interrupt request to ID stage.
- `irq_vector` out 8: vector address, valid while `irq_req`=1.
- `gie` out 1: global enable status.
- `pending` out `N_SRC`: pending register.
- `in_service` out `N_SRC`: one-hot in-service register, or 0.

## Operation
- Edge detect: `src_prev` <= `int_src` every cycle. `edge[i]` = `int_src[i]` & ~`src_prev[i]`.
- Pending: `pending[i]` is set on `edge[i]` & `mask[i]`, regardless of `gie` or FSM state, so events during service are not lost.
  - An edge on a masked source is discarded.
  - A repeat edge while already pending merges into the one pending bit.
  - Set and ack-clear on the same bit in the same cycle: set wins.
- Mask: `mask` <= `mask_wdata` on `mask_we`. Clearing a mask bit does not clear its pending bit, but the source becomes ineligible.
- Global enable:
  - `gie_set` or `reti` sets `gie`; `gie_clr` clears it.
  - If set and clear arrive together, set wins.
  - Ack clears `gie` automatically, with priority over `gie_set` in the same cycle.
- Eligible = `pending` & `mask`. `sel` = lowest set index of eligible.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if `gie` & |eligible, go to REQ, latch `sel`, set `irq_req`<=1, and set `irq_vector`<=`VEC_BASE` + `sel`*`VEC_STEP` (8-bit, modulo 256).
  - REQ: hold `irq_req`, `irq_vector` and the latched `sel` stable. Later higher-priority arrivals and mask changes do not alter the request. The following events are checked in order:
    1. `irq_ack`: clear `pending[sel]`, set `in_service[sel]`, clear `gie`, set `irq_req`<=0 and `irq_vector`<=0, go to SERVICE.
    2. `gie_clr` without ack: withdraw. Set `irq_req`<=0 and `irq_vector`<=0, go to IDLE; pending is kept.
    3. Ack with `gie_clr` in the same cycle: ack wins.
  - SERVICE: no new requests. On `reti`: clear `in_service`, set `gie`, go to IDLE.
- Spurious inputs: `irq_ack` outside REQ is ignored. `reti` outside SERVICE only sets `gie`.
- Reset (`rst`=0), effective at the next edge:
  - State = IDLE.
  - `irq_req`=0, `irq_vector`=0, `gie`=0.
  - `pending`=0, `in_service`=0, `src_prev`=0.
  - `mask` = all ones.
  - Reset mid-REQ or mid-SERVICE aborts with no ack or RETI needed.
  - A source held high at reset release produces one edge.

## Timing
- All outputs are registered.
- Edge to request: `int_src` rises, first sampled high at edge t.
  - `pending` is set after t.
  - IDLE evaluates in cycle t+1, so `irq_req`=1 after edge t+1: 2 cycles.
- Ack to deassert: `irq_ack` sampled at edge a gives `irq_req`=0 and `in_service` set after edge a, i.e. 1 cycle.
- RETI to next request: `reti` sampled at edge r gives IDLE and `gie`=1 after r. A waiting pending source gives `irq_req`=1 after edge r+1.
- Back-to-back: a minimum of 2 cycles from `reti` to the next `irq_req`.
- `irq_ack` may arrive any number of cycles after `irq_req`, including the first cycle it is high.

## Test plan
- Basic request: reset, `gie_set`, pulse `int_src[1]`.
  - Expect `irq_req` 2 cycles later with `irq_vector`=8'h04.
  - Ack gives `in_service`=4'b0010, `gie`=0, `pending`=0.
  - `reti` restores `gie`=1.
- Priority: `int_src[2]` and `int_src[0]` rise in the same cycle with `gie`=1.
  - Expect vector 8'h02 first, with `pending[2]` still set.
  - After ack and `reti`, the next request has vector 8'h06.
- Event during service: while in SERVICE, raise `int_src[3]`.
  - `pending[3]` sets, and no `irq_req` is asserted during SERVICE.
  - After `reti` at edge r, `irq_req`=1 after r+1 with vector 8'h08.
- Mask and merge:
  - With `mask`=4'b1110, an edge on source 0 leaves `pending`=0.
  - Two edges on source 1 while `gie`=0 give a single pending bit; `gie_set` then yields exactly one request.
- Withdraw and race:
  - `gie_clr` in REQ without ack drops `irq_req` next cycle with `pending` kept.
  - A repeat with `irq_ack` and `gie_clr` in the same cycle must enter SERVICE.
- Reset mid-service: drive `rst`=0 during SERVICE. All outputs return to reset values after one edge, with `mask`=4'b1111.

Source files
------------

// File: rtl/kontroler_przerwan.sv
// Vectored interrupt controller: edge-latched pending sources, per-source mask,
// global enable, fixed lowest-index priority and req/ack handshake to the ID stage.
module kontroler_przerwan #(
  parameter int unsigned N_SRC    = 4,
  parameter logic [7:0]  VEC_BASE = 8'h02,
  parameter logic [7:0]  VEC_STEP = 8'h02
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] int_src,
  input  logic             gie_set,
  input  logic             gie_clr,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             irq_ack,
  input  logic             reti,
  output logic             irq_req,
  output logic [7:0]       irq_vector,
  output logic             gie,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] src_prev_q;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] in_service_q, in_service_d;
  logic             gie_q, gie_d;
  logic             irq_req_q, irq_req_d;
  logic [7:0]       irq_vector_q, irq_vector_d;
  logic [2:0]       sel_q, sel_d;

  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] eligible;
  logic [2:0]       sel_w;
  logic             any_w;
  logic             ack_w;

  assign edges    = int_src & ~src_prev_q;
  assign eligible = pending_q & mask_q;
  assign ack_w    = (state_q == REQ) && irq_ack;

  // Lowest eligible index wins; the first hit freezes the search.
  always_comb begin
    sel_w = '0;
    any_w = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (eligible[i] && !any_w) begin
        sel_w = 3'(i);
        any_w = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    irq_req_d    = irq_req_q;
    irq_vector_d = irq_vector_q;
    in_service_d = in_service_q;
    pending_d    = pending_q;
    mask_d       = mask_we ? mask_wdata : mask_q;

    // Ack-clear first so a same-cycle edge on the same bit re-sets it.
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (ack_w && sel_q == 3'(i)) pending_d[i] = 1'b0;
    end
    pending_d = pending_d | (edges & mask_q);

    gie_d = gie_q;
    if (gie_clr)         gie_d = 1'b0;
    if (gie_set || reti) gie_d = 1'b1;
    if (ack_w)           gie_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (gie_q && any_w) begin
          state_d      = REQ;
          sel_d        = sel_w;
          irq_req_d    = 1'b1;
          irq_vector_d = VEC_BASE + {5'b0, sel_w} * VEC_STEP;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d      = SERVICE;
          irq_req_d    = 1'b0;
          irq_vector_d = '0;
          for (int unsigned i = 0; i < N_SRC; i++) begin
            in_service_d[i] = (sel_q == 3'(i));
          end
        end else if (gie_clr) begin
          state_d      = IDLE;
          irq_req_d    = 1'b0;
          irq_vector_d = '0;
        end
      end
      SERVICE: begin
        if (reti) begin
          state_d      = IDLE;
          in_service_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      src_prev_q   <= '0;
      mask_q       <= '1;
      pending_q    <= '0;
      in_service_q <= '0;
      gie_q        <= 1'b0;
      irq_req_q    <= 1'b0;
      irq_vector_q <= '0;
      sel_q        <= '0;
    end else begin
      state_q      <= state_d;
      src_prev_q   <= int_src;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      gie_q        <= gie_d;
      irq_req_q    <= irq_req_d;
      irq_vector_q <= irq_vector_d;
      sel_q        <= sel_d;
    end
  end

  assign irq_req    = irq_req_q;
  assign irq_vector = irq_vector_q;
  assign gie        = gie_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule
